// File: rtl/pulse_meter_pkg.sv
// -----------------------------------------------------------------------------
// pulse_meter_pkg
// Shared constants for the pulse-rate meter family and a helper that sizes
// the gate-window down-counter from the window length.
// No ports (package).
// -----------------------------------------------------------------------------
package pulse_meter_pkg;

    localparam int unsigned CLK_HZ            = 50_000_000;
    localparam int unsigned DEF_WINDOW_CYCLES = 4_250_000;
    localparam int unsigned DEF_CNT_W         = 8;

    // Smallest width w with 2**w > cycles, so WINDOW_CYCLES-1 always fits.
    function automatic int unsigned win_w_for(input int unsigned cycles);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'd1 << i) <= 64'(cycles)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/pulse_edge_counter.sv
// -----------------------------------------------------------------------------
// pulse_edge_counter
// One channel of the pulse-rate meter: synchroniser, history flop, edge
// qualifier, saturating accumulator and overflow bit.
//
// Ports:
//   i_clk         system clock
//   i_rst         asynchronous active-high reset
//   i_en          measurement enable; low clears acc/ovf
//   i_tc          window terminal cycle; acc/ovf clear after this cycle
//   i_both_edges  0 = rising edges only, 1 = rising and falling edges
//   i_pulse       raw asynchronous pulse input
//   o_close_cnt   acc plus this cycle's edge, saturated (value published at tc)
//   o_close_ovf   ovf including an overflow caused by this cycle's edge
// -----------------------------------------------------------------------------
module pulse_edge_counter
    import pulse_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_tc,
    input  logic             i_both_edges,
    input  logic             i_pulse,
    output logic [CNT_W-1:0] o_close_cnt,
    output logic             o_close_ovf
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic [CNT_W-1:0]       r_acc;
    logic                   r_ovf;

    logic                   w_sync;
    logic                   w_edge;
    logic                   w_at_max;
    logic [CNT_W-1:0]       w_sum;
    logic                   w_ovf_next;

    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_edge   = (w_sync & ~r_hist) | (i_both_edges & ~w_sync & r_hist);
    assign w_at_max = (r_acc == '1);

    // Sum including the current edge; this is also the closing value at tc,
    // so an edge in the terminal cycle lands in the window that is closing.
    assign w_sum      = (w_edge && !w_at_max) ? r_acc + CNT_W'(1) : r_acc;
    assign w_ovf_next = r_ovf | (w_edge & w_at_max);

    assign o_close_cnt = w_sum;
    assign o_close_ovf = w_ovf_next;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
            r_acc  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            // Synchroniser and history keep running while disabled, so a level
            // already high at enable is never seen as an edge.
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pulse};
            r_hist <= w_sync;
            if (!i_en || i_tc) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else begin
                r_acc <= w_sum;
                r_ovf <= w_ovf_next;
            end
        end
    end

endmodule

// File: rtl/pulse_rate_meter.sv
// -----------------------------------------------------------------------------
// pulse_rate_meter
// Multi-channel pulse-rate meter. Counts qualified edges on NCH asynchronous
// inputs over a shared gate window of WINDOW_CYCLES clocks and publishes all
// channel counts together with a one-cycle valid strobe.
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-high reset
//   en          measurement enable; low stops windows and clears accumulators
//   both_edges  0 = count rising edges, 1 = count rising and falling edges
//   pulse_in    raw asynchronous pulse inputs, one bit per channel
//   speed       latched per-channel counts, channel i at [i*CNT_W +: CNT_W]
//   sat         per-channel saturation flag of the last published window
//   valid       one-cycle strobe: speed/sat updated this cycle
// -----------------------------------------------------------------------------
module pulse_rate_meter
    import pulse_meter_pkg::*;
#(
    parameter int unsigned NCH           = 2,
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int unsigned WIN_W         = win_w_for(WINDOW_CYCLES),
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 both_edges,
    input  logic [NCH-1:0]       pulse_in,
    output logic [NCH*CNT_W-1:0] speed,
    output logic [NCH-1:0]       sat,
    output logic                 valid
);

    localparam logic [WIN_W-1:0] WIN_RELOAD = WIN_W'(WINDOW_CYCLES - 1);

    logic [WIN_W-1:0]       r_win;
    logic [NCH*CNT_W-1:0]   r_speed;
    logic [NCH-1:0]         r_sat;
    logic                   r_valid;

    logic                   w_tc;
    logic [NCH*CNT_W-1:0]   w_close_cnt;
    logic [NCH-1:0]         w_close_ovf;

    // r_win only reaches 0 after a run of enabled cycles (en low reloads it),
    // so tc needs no en term; this lets a window whose tc coincides with en
    // falling still publish.
    assign w_tc = (r_win == '0);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        pulse_edge_counter #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_cnt (
            .i_clk        (clk),
            .i_rst        (reset),
            .i_en         (en),
            .i_tc         (w_tc),
            .i_both_edges (both_edges),
            .i_pulse      (pulse_in[g]),
            .o_close_cnt  (w_close_cnt[g*CNT_W +: CNT_W]),
            .o_close_ovf  (w_close_ovf[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win   <= WIN_RELOAD;
            r_speed <= '0;
            r_sat   <= '0;
            r_valid <= 1'b0;
        end else begin
            if (!en || w_tc) begin
                r_win <= WIN_RELOAD;
            end else begin
                r_win <= r_win - WIN_W'(1);
            end
            r_valid <= w_tc;
            if (w_tc) begin
                r_speed <= w_close_cnt;
                r_sat   <= w_close_ovf;
            end
        end
    end

    assign speed = r_speed;
    assign sat   = r_sat;
    assign valid = r_valid;

endmodule

// File: tb/tb_pulse_rate_meter.sv
module tb_pulse_rate_meter;

    typedef struct {
        int   h0;     // ch0 half period in cycles, 0 = hold l0
        logic l0;
        int   h1;
        logic both;
        int   e8_0;
        int   e8_1;
        int   e8_sat;
        int   e4_0;
        int   e4_1;
        int   e4_sat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        both_edges;
    logic [1:0]  pulse_in = 2'b00;
    logic [15:0] speed8;
    logic [1:0]  sat8;
    logic        valid8;
    logic [7:0]  speed4;
    logic [1:0]  sat4;
    logic        valid4;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   g_half [2];
    logic g_lvl  [2];
    int   g_cnt  [2];
    vec_t vecs   [6];

    always #5 clk = ~clk;

    pulse_rate_meter #(
        .NCH(2), .CNT_W(8), .WINDOW_CYCLES(100), .WIN_W(7), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .both_edges(both_edges),
        .pulse_in(pulse_in), .speed(speed8), .sat(sat8), .valid(valid8)
    );

    pulse_rate_meter #(
        .NCH(2), .CNT_W(4), .WINDOW_CYCLES(100), .WIN_W(7), .SYNC_STAGES(2)
    ) dut4 (
        .clk(clk), .reset(reset), .en(en), .both_edges(both_edges),
        .pulse_in(pulse_in), .speed(speed4), .sat(sat4), .valid(valid4)
    );

    // Pulse generator: square wave of period 2*half, or a static level.
    initial begin
        g_cnt[0] = 0;
        g_cnt[1] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int ch = 0; ch < 2; ch++) begin
                if (g_half[ch] == 0) begin
                    pulse_in[ch] = g_lvl[ch];
                end else begin
                    g_cnt[ch]++;
                    if (g_cnt[ch] >= g_half[ch]) begin
                        g_cnt[ch] = 0;
                        pulse_in[ch] = ~pulse_in[ch];
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Returns the number of negedges until valid is seen (bounded).
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid8 && n < 400);
        if (!valid8) chk("valid_timeout", 0, 1);
    endtask

    task automatic check_out(input string name, input int e80, input int e81, input int e8s,
                             input int e40, input int e41, input int e4s);
        chk({name, ".s8_ch0"}, int'(speed8[7:0]),  e80);
        chk({name, ".s8_ch1"}, int'(speed8[15:8]), e81);
        chk({name, ".sat8"},   int'(sat8),         e8s);
        chk({name, ".s4_ch0"}, int'(speed4[3:0]),  e40);
        chk({name, ".s4_ch1"}, int'(speed4[7:4]),  e41);
        chk({name, ".sat4"},   int'(sat4),         e4s);
        chk({name, ".valid4"}, int'(valid4),       1);
    endtask

    initial begin
        int   n;
        logic hold_ok;

        vecs[0] = '{h0:5,  l0:1'b0, h1:0, both:1'b0, e8_0:10,  e8_1:0,  e8_sat:0, e4_0:10, e4_1:0,  e4_sat:0};
        vecs[1] = '{h0:5,  l0:1'b0, h1:0, both:1'b1, e8_0:20,  e8_1:0,  e8_sat:0, e4_0:15, e4_1:0,  e4_sat:1};
        vecs[2] = '{h0:0,  l0:1'b1, h1:0, both:1'b1, e8_0:0,   e8_1:0,  e8_sat:0, e4_0:0,  e4_1:0,  e4_sat:0};
        vecs[3] = '{h0:2,  l0:1'b0, h1:0, both:1'b0, e8_0:25,  e8_1:0,  e8_sat:0, e4_0:15, e4_1:0,  e4_sat:1};
        vecs[4] = '{h0:25, l0:1'b0, h1:0, both:1'b0, e8_0:2,   e8_1:0,  e8_sat:0, e4_0:2,  e4_1:0,  e4_sat:0};
        vecs[5] = '{h0:1,  l0:1'b0, h1:5, both:1'b1, e8_0:100, e8_1:20, e8_sat:0, e4_0:15, e4_1:15, e4_sat:3};

        reset = 1'b1;
        en = 1'b1;
        both_edges = 1'b0;
        g_half[0] = 0; g_half[1] = 0;
        g_lvl[0] = 1'b0; g_lvl[1] = 1'b0;

        // Reset held
        repeat (3) @(negedge clk);
        chk("rst_speed8", int'(speed8), 0);
        chk("rst_valid8", int'(valid8), 0);
        chk("rst_sat8",   int'(sat8),   0);
        chk("rst_speed4", int'(speed4), 0);

        // First valid after release: 101st cycle counting the release cycle as 1
        @(posedge clk); #1 reset = 1'b0;
        wait_valid(n);
        chk("rst_first_valid_cycles", n, 101);
        check_out("rst_first", 0, 0, 0, 0, 0, 0);

        // Table-driven steady-state windows
        for (int i = 0; i < 6; i++) begin
            g_half[0] = vecs[i].h0; g_lvl[0] = vecs[i].l0;
            g_half[1] = vecs[i].h1; g_lvl[1] = 1'b0;
            both_edges = vecs[i].both;
            wait_valid(n);
            chk($sformatf("vec%0d.spacing_a", i), n, 100);
            wait_valid(n);
            chk($sformatf("vec%0d.spacing_b", i), n, 100);
            check_out($sformatf("vec%0d", i), vecs[i].e8_0, vecs[i].e8_1, vecs[i].e8_sat,
                      vecs[i].e4_0, vecs[i].e4_1, vecs[i].e4_sat);
        end
        g_half[1] = 0; g_lvl[1] = 1'b0;
        both_edges = 1'b0;

        // Saturation then recovery with 3 edges
        g_half[0] = 2;
        wait_valid(n);
        wait_valid(n);
        chk("sat_s4", int'(speed4[3:0]), 15);
        chk("sat_flag4", int'(sat4[0]), 1);
        g_half[0] = 0; g_lvl[0] = 1'b0;
        wait_valid(n);
        for (int k = 0; k < 3; k++) begin
            repeat (4) @(negedge clk); g_lvl[0] = 1'b1;
            repeat (4) @(negedge clk); g_lvl[0] = 1'b0;
        end
        wait_valid(n);
        chk("recover_s4", int'(speed4[3:0]), 3);
        chk("recover_sat4", int'(sat4[0]), 0);
        chk("recover_s8", int'(speed8[7:0]), 3);

        // Single rising edge reaching the qualifier in the tc cycle
        repeat (96) @(negedge clk);
        g_lvl[0] = 1'b1;
        wait_valid(n);
        chk("tc_edge_s8", int'(speed8[7:0]), 1);
        chk("tc_edge_s4", int'(speed4[3:0]), 1);
        wait_valid(n);
        chk("after_tc_s8", int'(speed8[7:0]), 0);

        // Enable gating
        g_half[0] = 5;
        wait_valid(n);
        wait_valid(n);
        chk("gate_pre_s8", int'(speed8[7:0]), 10);
        repeat (40) @(posedge clk);
        #1 en = 1'b0;
        g_half[0] = 0; g_lvl[0] = 1'b1;
        hold_ok = 1'b1;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (valid8 || speed8[7:0] != 8'd10 || speed4[3:0] != 4'd10) hold_ok = 1'b0;
        end
        chk("gate_hold", int'(hold_ok), 1);
        @(posedge clk); #1 en = 1'b1;
        wait_valid(n);
        chk("gate_first_valid_cycles", n, 101);
        chk("gate_no_spurious_s8", int'(speed8[7:0]), 0);

        // en falls in the tc cycle: that window still publishes
        g_half[0] = 5;
        wait_valid(n);
        repeat (99) @(posedge clk);
        #1 en = 1'b0;
        wait_valid(n);
        chk("en_tc_latency", n, 2);
        chk("en_tc_s8", int'(speed8[7:0]), 10);
        @(negedge clk);
        chk("en_tc_strobe_len", int'(valid8), 0);
        @(posedge clk); #1 en = 1'b1;
        wait_valid(n);
        chk("pre_rst_s8", int'(speed8[7:0]), 10);

        // Asynchronous reset between clock edges
        repeat (50) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("async_rst_speed8", int'(speed8), 0);
        chk("async_rst_speed4", int'(speed4), 0);
        chk("async_rst_valid",  int'(valid8), 0);
        chk("async_rst_sat",    int'(sat8),   0);
        g_half[0] = 0; g_lvl[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        wait_valid(n);
        chk("rst2_first_valid_cycles", n, 101);
        chk("rst2_s8", int'(speed8[7:0]), 0);
        @(negedge clk);
        chk("rst2_strobe_len", int'(valid8), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
